// File: rtl/tlp_pndgrd_ctrl.sv
// Memory-read issue sequencer: arbitrates two requesters, tags reads, feeds TX and the pending-read FIFO.
// Grant-to-TxRdValid 1 cycle; holds header under TxRdReady low; grants stall on no free tag or FIFO near full.
module tlp_pndgrd_ctrl #(
   parameter int C_NUM_TAGS    = 8,
   parameter int C_FIFO_THRESH = 14,
   parameter int C_TMO_W       = 16,
   parameter int C_TMO_CYCLES  = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Req0Valid,
   input  logic [48:0] Req0Hdr,
   output logic        Req0Ack,
   input  logic        Req1Valid,
   input  logic [48:0] Req1Hdr,
   output logic        Req1Ack,
   output logic        TxRdValid,
   output logic [56:0] TxRdHdr,
   input  logic        TxRdReady,
   output logic        PndgRdFifoWrReq,
   output logic [56:0] PndgRdHeader,
   input  logic [3:0]  PndngRdFifoUsedW,
   input  logic        CplValid,
   input  logic [7:0]  CplTag,
   input  logic        CplLast,
   output logic        TmoValid,
   output logic [7:0]  TmoTag,
   output logic        CplErr,
   output logic [4:0]  OutstandingCnt
);

   typedef struct packed {
      logic [7:0]  tag;
      logic [48:0] hdr;
   } tagHdr_t;

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [C_TMO_W-1:0] TMO_LIMIT = C_TMO_W'(C_TMO_CYCLES);
   localparam logic [15:0]        TAG_MASK  = 16'((32'd1 << C_NUM_TAGS) - 32'd1);
   localparam logic [4:0]         THRESH    = 5'(C_FIFO_THRESH);

   state_t               state, stateNxt;
   logic [15:0]          busy, busyNxt;
   logic [C_TMO_W-1:0]   tmoCnt [16];
   logic                 rrPtr;
   logic                 winQ;
   tagHdr_t              issueQ;

   logic                 grant, grantWin, accept;
   logic                 anyFree;
   logic [3:0]           freeTag;
   logic [3:0]           cplIdx;
   logic                 cplHit, cplFree;
   logic                 tmoHit;
   logic [3:0]           tmoIdx;
   logic [15:0]          setMask, clrMask;

   function automatic logic [4:0] popCount(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   // Lowest free tag, taken from the registered bitmap only.
   always_comb begin
      anyFree = 1'b0;
      freeTag = '0;
      for (int t = 15; t >= 0; t--) begin
         if (TAG_MASK[t] && !busy[t]) begin
            anyFree = 1'b1;
            freeTag = 4'(t);
         end
      end
   end

   always_comb begin
      cplIdx  = CplTag[3:0];
      cplHit  = CplValid && (CplTag < 8'(C_NUM_TAGS)) && busy[cplIdx];
      cplFree = cplHit && CplLast;
   end

   // A completion-last on a saturated tag pre-empts its timeout report.
   always_comb begin
      tmoHit = 1'b0;
      tmoIdx = '0;
      for (int t = 15; t >= 0; t--) begin
         if (busy[t] && (tmoCnt[t] == TMO_LIMIT) && !(cplFree && (cplIdx == 4'(t)))) begin
            tmoHit = 1'b1;
            tmoIdx = 4'(t);
         end
      end
   end

   always_comb begin
      stateNxt = state;
      grant    = 1'b0;
      accept   = 1'b0;
      grantWin = (Req0Valid && Req1Valid) ? rrPtr : Req1Valid;
      case (state)
         IDLE: begin
            if ((Req0Valid || Req1Valid) && anyFree && ({1'b0, PndngRdFifoUsedW} < THRESH)) begin
               grant    = 1'b1;
               stateNxt = ISSUE;
            end
         end
         ISSUE: begin
            if (TxRdReady) begin
               accept   = 1'b1;
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_comb begin
      setMask = accept  ? (16'd1 << issueQ.tag[3:0]) : 16'd0;
      clrMask = (cplFree ? (16'd1 << cplIdx) : 16'd0) |
                (tmoHit  ? (16'd1 << tmoIdx) : 16'd0);
      busyNxt = (busy | setMask) & ~clrMask & TAG_MASK;
   end

   assign TxRdValid       = (state == ISSUE);
   assign TxRdHdr         = issueQ;
   assign PndgRdHeader    = issueQ;
   assign PndgRdFifoWrReq = accept;
   assign Req0Ack         = accept && !winQ;
   assign Req1Ack         = accept &&  winQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         busy           <= '0;
         rrPtr          <= 1'b0;
         winQ           <= 1'b0;
         issueQ         <= '0;
         TmoValid       <= 1'b0;
         TmoTag         <= '0;
         CplErr         <= 1'b0;
         OutstandingCnt <= '0;
         for (int t = 0; t < 16; t++) tmoCnt[t] <= '0;
      end else begin
         state          <= stateNxt;
         busy           <= busyNxt;
         OutstandingCnt <= popCount(busyNxt);
         CplErr         <= CplValid && !cplHit;
         TmoValid       <= tmoHit;
         TmoTag         <= tmoHit ? {4'h0, tmoIdx} : 8'h00;
         if (grant) begin
            issueQ.tag <= {4'h0, freeTag};
            issueQ.hdr <= grantWin ? Req1Hdr : Req0Hdr;
            winQ       <= grantWin;
         end
         if (accept) rrPtr <= !winQ;
         for (int t = 0; t < 16; t++) begin
            if (setMask[t])
               tmoCnt[t] <= '0;
            else if (busy[t] && (tmoCnt[t] != TMO_LIMIT))
               tmoCnt[t] <= tmoCnt[t] + C_TMO_W'(1);
         end
      end
   end

endmodule

// File: doc/tlp_pndgrd_ctrl.md
Name: tlp_pndgrd_ctrl

Overview:
- Sequencer for non-posted memory-read issue on the PCIe TX path, sitting in front of the pending-read FIFO.
- Arbitrates two read requesters (DMA engine, AXI slave bridge) and allocates a TLP tag to each read.
- Hands the tagged header to the TX engine, then pushes the same header into the pending-read FIFO for the RX completion matcher.
- Tracks outstanding tags, frees them on final completion, and retires them on completion timeout.

Parameters:
C_NUM_TAGS, 8, number of tags in use (2..16); tags issued are 0..C_NUM_TAGS-1, tag bits [7:4] are always 0.
C_FIFO_THRESH, 14, issue is blocked while PndngRdFifoUsedW >= this value (FIFO depth 16).
C_TMO_W, 16, width of each per-tag timeout counter.
C_TMO_CYCLES, 50000, clk cycles from issue to timeout (must fit in C_TMO_W).

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
Req0Valid  in  1  DMA read request; held until acked
Req0Hdr  in  49  DMA read header, without tag
Req0Ack  out  1  one-cycle grant-complete pulse to requester 0
Req1Valid  in  1  AXI bridge read request; held until acked
Req1Hdr  in  49  AXI bridge read header, without tag
Req1Ack  out  1  one-cycle grant-complete pulse to requester 1
TxRdValid  out  1  tagged read TLP header valid to TX engine
TxRdHdr  out  57  {tag[7:0], hdr[48:0]}
TxRdReady  in  1  TX engine accepts the header
PndgRdFifoWrReq  out  1  pending-read FIFO write strobe
PndgRdHeader  out  57  pending-read FIFO write data (same value as TxRdHdr)
PndngRdFifoUsedW  in  4  pending-read FIFO fill level
CplValid  in  1  completion seen by RX
CplTag  in  8  tag of that completion
CplLast  in  1  final completion for the tag (byte count exhausted)
TmoValid  out  1  one-cycle timeout pulse
TmoTag  out  8  tag that timed out
CplErr  out  1  one-cycle pulse: completion received for a non-busy tag
OutstandingCnt  out  5  number of busy tags

Behaviour:
- Reset: all outputs 0, busy bitmap cleared, counters cleared, FSM in IDLE, RR pointer = requester 0. Reset assertion mid-transfer drops TxRdValid immediately; no FIFO write or Ack follows.
- FSM IDLE: a grant occurs when all of the following hold:
  - (Req0Valid | Req1Valid),
  - at least one tag is free,
  - PndngRdFifoUsedW < C_FIFO_THRESH.
- On a grant:
  - Winner is chosen round-robin: if both are valid, the RR pointer side wins; if only one is valid, that one wins.
  - The lowest-numbered free tag is latched together with the winner's header.
  - FSM goes to ISSUE.
- FSM ISSUE: TxRdValid = 1 with the header held stable. On the cycle TxRdValid & TxRdReady:
  - the tag is marked busy and its counter is loaded to 0;
  - PndgRdFifoWrReq = 1 for exactly that cycle, with PndgRdHeader = TxRdHdr;
  - the winner's ReqNAck pulses;
  - the RR pointer moves to the other requester;
  - FSM goes to IDLE.
- Throughput: minimum 2 cycles per read; grant-to-TxRdValid latency is 1 cycle.
- A requester must not drop ReqValid before its Ack. Header capture happens at grant, so later header changes are ignored.
- Completion handling:
  - CplValid & CplLast on a busy tag frees it next cycle.
  - CplValid & !CplLast on a busy tag changes nothing.
  - CplValid on a non-busy tag, or CplTag >= C_NUM_TAGS, pulses CplErr and changes no state.
- Timeout:
  - Each busy tag's counter increments every cycle and saturates at C_TMO_CYCLES.
  - A tag at C_TMO_CYCLES is reported via TmoValid/TmoTag, lowest tag first, one per cycle, and freed in the same cycle.
  - Other saturated tags wait their turn.
- Simultaneous events:
  - Completion-last and timeout reported on the same tag in the same cycle: the completion wins; no TmoValid, CplErr = 0.
  - A tag freed this cycle is not allocatable until the next IDLE evaluation; allocation uses the registered bitmap.
  - Issue (marking a tag busy) and a free of a different tag in the same cycle are both honoured.
- OutstandingCnt is the registered popcount of the busy bitmap, updated one cycle after the change; it never exceeds C_NUM_TAGS.
- FIFO throttle is evaluated only in IDLE. A grant already in ISSUE completes even if UsedW rises. C_FIFO_THRESH=14 absorbs the one in-flight write.

Test Plan:
1. Req0Valid alone, Req0Hdr=49'h1_2345, TxRdReady=1:
   - TxRdValid 1 cycle after the grant, TxRdHdr = {8'h00, hdr};
   - PndgRdFifoWrReq and Req0Ack on the same cycle;
   - OutstandingCnt=1 the following cycle.
2. Both requesters continuously valid, 4 grants:
   - order is Req0, Req1, Req0, Req1 with tags 0, 1, 2, 3;
   - TxRdReady held 0 for 3 cycles on grant 2: header stable, no FIFO write until accept.
3. Issue 8 reads with no completions:
   - 9th request is not granted; OutstandingCnt=8;
   - CplValid/CplLast on tag 5 → the next grant gets tag 5.
4. PndngRdFifoUsedW=14 with Req1Valid:
   - no grant;
   - drop UsedW to 13 → grant the next cycle.
5. C_TMO_CYCLES=20, tags 0 and 1 issued on consecutive grants:
   - TmoValid with tag 0, then tag 1, each freed;
   - CplLast on tag 1 in the same cycle as its timeout → no TmoValid for tag 1.
6. CplValid on idle tag 3 → CplErr pulse, OutstandingCnt unchanged. Assert rst_n low while in ISSUE → TxRdValid=0 immediately, all state cleared.
